seg7_scan_driver: RTL

- Reader side of the keypad digit buffer: takes the 16-bit packed 4-digit value (4 nibbles, digit 3 = bits 15:12) and drives a time-multiplexed, common-anode 4-digit 7-segment display.
- Updates are captured on a load strobe and applied only at frame boundaries, so a scan frame never shows a mix of old and new digits.
- Sits between the digit-entry buffer and the board display pins.

---
 rtl/seg7_scan_driver_pkg.sv | 42 ++++
 rtl/seg7_hex_decode.sv | 32 +++
 rtl/seg7_scan_driver.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/seg7_scan_driver_pkg.sv
// Shared definitions for the 4-digit multiplexed 7-segment scan driver:
// segment patterns, digit count, scan FSM encoding and leading-zero helper.
package seg7_scan_driver_pkg;

  localparam int NUM_DIGITS = 4;
  localparam logic [1:0] LAST_DIGIT = 2'(NUM_DIGITS - 1);

  // Active-low patterns, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_0   = 7'h40;
  localparam logic [6:0] SEG_1   = 7'h79;
  localparam logic [6:0] SEG_2   = 7'h24;
  localparam logic [6:0] SEG_3   = 7'h30;
  localparam logic [6:0] SEG_4   = 7'h19;
  localparam logic [6:0] SEG_5   = 7'h12;
  localparam logic [6:0] SEG_6   = 7'h02;
  localparam logic [6:0] SEG_7   = 7'h78;
  localparam logic [6:0] SEG_8   = 7'h00;
  localparam logic [6:0] SEG_9   = 7'h10;
  localparam logic [6:0] SEG_A   = 7'h08;
  localparam logic [6:0] SEG_B   = 7'h03;
  localparam logic [6:0] SEG_C   = 7'h46;
  localparam logic [6:0] SEG_D   = 7'h21;
  localparam logic [6:0] SEG_E   = 7'h06;
  localparam logic [6:0] SEG_F   = 7'h0E;
  localparam logic [6:0] SEG_OFF = 7'h7F;

  typedef enum logic [0:0] {
    ST_GAP = 1'b0,
    ST_ON  = 1'b1
  } scan_state_e;

  // A digit is blanked when it and every digit to its left are zero; digit0 always shows.
  function automatic logic [NUM_DIGITS-1:0] lead_blank_mask(input logic [15:0] digits);
    logic [NUM_DIGITS-1:0] m;
    m[3] = (digits[15:12] == 4'h0);
    m[2] = m[3] & (digits[11:8] == 4'h0);
    m[1] = m[2] & (digits[7:4] == 4'h0);
    m[0] = 1'b0;
    return m;
  endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational hex nibble to active-low 7-segment pattern decoder.
module seg7_hex_decode (
  input  logic [3:0] nibble,
  output logic [6:0] seg_n
);
  import seg7_scan_driver_pkg::*;

  // Nibble to segment lookup
  always_comb begin
    seg_n = SEG_OFF;
    case (nibble)
      4'h0:    seg_n = SEG_0;
      4'h1:    seg_n = SEG_1;
      4'h2:    seg_n = SEG_2;
      4'h3:    seg_n = SEG_3;
      4'h4:    seg_n = SEG_4;
      4'h5:    seg_n = SEG_5;
      4'h6:    seg_n = SEG_6;
      4'h7:    seg_n = SEG_7;
      4'h8:    seg_n = SEG_8;
      4'h9:    seg_n = SEG_9;
      4'hA:    seg_n = SEG_A;
      4'hB:    seg_n = SEG_B;
      4'hC:    seg_n = SEG_C;
      4'hD:    seg_n = SEG_D;
      4'hE:    seg_n = SEG_E;
      4'hF:    seg_n = SEG_F;
      default: seg_n = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed common-anode 4-digit display driver with frame-aligned
// digit updates, leading-zero blanking and anti-ghosting gaps.
module seg7_scan_driver #(
  parameter int REFRESH_DIV   = 50000,
  parameter int GAP_CYCLES    = 4,
  parameter bit BLANK_LEADING = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] digit_buffer,
  input  logic        load,
  input  logic [3:0]  dp_mask,
  input  logic        blank_all,
  output logic [6:0]  seg_n,
  output logic        dp_n,
  output logic [3:0]  an_n,
  output logic        frame_done,
  output logic        load_pending
);
  import seg7_scan_driver_pkg::*;

  localparam int CNT_MAX = (REFRESH_DIV > GAP_CYCLES) ? REFRESH_DIV : GAP_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] ON_LAST  = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  scan_state_e            state_q, state_d;
  logic [1:0]             idx_q, idx_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [15:0]            shadow_q, shadow_d;
  logic [15:0]            pending_q, pending_d;
  logic                   load_pending_q, load_pending_d;
  logic [6:0]             seg_n_q, seg_n_d;
  logic                   dp_n_q, dp_n_d;
  logic [3:0]             an_n_q, an_n_d;
  logic                   frame_done_q, frame_done_d;
  logic [3:0]             cur_nibble_s;
  logic [6:0]             dec_seg_s;
  logic [NUM_DIGITS-1:0]  blank_mask_s;
  logic                   digit_lit_s;

  // Scan FSM state, digit index and phase counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_GAP;
      idx_q   <= 2'd0;
      cnt_q   <= CNT_ZERO;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
    end
  end

  // Scan FSM next-state: GAP_CYCLES dark, then REFRESH_DIV lit, then next digit
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q + CNT_ONE;
    case (state_q)
      ST_GAP: begin
        if (cnt_q == GAP_LAST) begin
          state_d = ST_ON;
          cnt_d   = CNT_ZERO;
        end else begin
          state_d = ST_GAP;
        end
      end
      ST_ON: begin
        if (cnt_q == ON_LAST) begin
          state_d = ST_GAP;
          idx_d   = idx_q + 2'd1;
          cnt_d   = CNT_ZERO;
        end else begin
          state_d = ST_ON;
        end
      end
      default: begin
        state_d = ST_GAP;
        idx_d   = 2'd0;
        cnt_d   = CNT_ZERO;
      end
    endcase
  end

  assign cur_nibble_s = shadow_q[{idx_q, 2'b00} +: 4];

  seg7_hex_decode u_dec (
    .nibble (cur_nibble_s),
    .seg_n  (dec_seg_s)
  );

  // Leading-zero mask and whether the current digit is actually lit
  always_comb begin
    blank_mask_s = {NUM_DIGITS{1'b0}};
    if (BLANK_LEADING) begin
      blank_mask_s = lead_blank_mask(shadow_q);
    end else begin
      blank_mask_s = {NUM_DIGITS{1'b0}};
    end
    digit_lit_s = (state_q == ST_ON) && !blank_mask_s[idx_q];
  end

  // Pin values derived from the current FSM state, registered below
  always_comb begin
    an_n_d       = 4'hF;
    seg_n_d      = SEG_OFF;
    dp_n_d       = 1'b1;
    frame_done_d = (state_q == ST_ON) && (idx_q == LAST_DIGIT) && (cnt_q == ON_LAST);
    if (digit_lit_s) begin
      seg_n_d = dec_seg_s;
      dp_n_d  = ~dp_mask[idx_q];
      if (blank_all) begin
        an_n_d = 4'hF;
      end else begin
        an_n_d = ~(4'b0001 << idx_q);
      end
    end else begin
      an_n_d  = 4'hF;
      seg_n_d = SEG_OFF;
      dp_n_d  = 1'b1;
    end
  end

  // Output pin registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an_n_q       <= 4'hF;
      seg_n_q      <= SEG_OFF;
      dp_n_q       <= 1'b1;
      frame_done_q <= 1'b0;
    end else begin
      an_n_q       <= an_n_d;
      seg_n_q      <= seg_n_d;
      dp_n_q       <= dp_n_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Load path: latest load waits in pending and is promoted on the frame_done cycle.
  // A load coinciding with frame_done also refreshes pending so the next promotion keeps it.
  always_comb begin
    shadow_d       = shadow_q;
    pending_d      = pending_q;
    load_pending_d = load_pending_q;
    if (frame_done_q) begin
      load_pending_d = 1'b0;
      if (load) begin
        shadow_d  = digit_buffer;
        pending_d = digit_buffer;
      end else begin
        shadow_d  = pending_q;
      end
    end else if (load) begin
      pending_d      = digit_buffer;
      load_pending_d = 1'b1;
    end else begin
      load_pending_d = load_pending_q;
    end
  end

  // Shadow / pending digit registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_q       <= 16'h0000;
      pending_q      <= 16'h0000;
      load_pending_q <= 1'b0;
    end else begin
      shadow_q       <= shadow_d;
      pending_q      <= pending_d;
      load_pending_q <= load_pending_d;
    end
  end

  assign seg_n        = seg_n_q;
  assign dp_n         = dp_n_q;
  assign an_n         = an_n_q;
  assign frame_done   = frame_done_q;
  assign load_pending = load_pending_q;

endmodule
